// File: rtl/regbank_pkg.sv
// Shared widths and requester encoding for the register-bank writeback arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package regbank_pkg;

  // Default register address and data widths.
  localparam int DEF_WIDTH_ADDR = 5;
  localparam int DEF_WIDTH_DATA = 32;

  // Requester index: A is the ALU writeback, B is the load writeback.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } reqIdx_t;

  // The requester that gets priority after the given one wins a contended grant.
  function automatic reqIdx_t otherReq(input reqIdx_t r);
    return (r == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Busy-bit scoreboard with a registered population count of the busy registers.
// Latency: set/clear take effect at the next edge; busy lookups are combinational from the registered bits.
// Backpressure: none; a set and a clear are accepted every cycle, and the set wins on the same address.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int WIDTH_ADDR_LENGTH = DEF_WIDTH_ADDR,
  parameter int NUM_REG_BANK      = 1 << WIDTH_ADDR_LENGTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         setEn,
  input  logic [WIDTH_ADDR_LENGTH-1:0] setAddr,
  input  logic                         clrEn,
  input  logic [WIDTH_ADDR_LENGTH-1:0] clrAddr,
  input  logic [WIDTH_ADDR_LENGTH-1:0] lookA,
  input  logic [WIDTH_ADDR_LENGTH-1:0] lookB,
  output logic                         busyA,
  output logic                         busyB,
  output logic [WIDTH_ADDR_LENGTH:0]   pending
);

  localparam int CW = WIDTH_ADDR_LENGTH + 1;

  logic [NUM_REG_BANK-1:0] busy;
  logic [NUM_REG_BANK-1:0] busyNext;
  logic [CW-1:0]           countNext;

  // Next busy vector: the clear is applied first so a same-cycle set overrides it; register 0 is never busy
  always_comb begin
    busyNext = busy;
    if (clrEn) begin
      busyNext[clrAddr] = 1'b0;
    end
    if (setEn && (setAddr != '0)) begin
      busyNext[setAddr] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  // Population count of the next busy vector so the count is registered together with the bits
  always_comb begin
    countNext = '0;
    for (int i = 0; i < NUM_REG_BANK; i++) begin
      countNext = countNext + CW'(busyNext[i]);
    end
  end

  // Busy bits and their count, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= '0;
      pending <= '0;
    end else begin
      busy    <= busyNext;
      pending <= countNext;
    end
  end

  assign busyA = busy[lookA];
  assign busyB = busy[lookB];

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Round-robin arbiter of two writeback requesters onto one register-bank write port, with a busy scoreboard.
// Latency: ready is combinational; the write port is registered one cycle after the grant.
// Backpressure: the loser of a contended cycle sees ready low and must hold its request until accepted.
module regbank_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int WIDTH_ADDR_LENGTH = DEF_WIDTH_ADDR,
  parameter int WIDTH_DATA_LENGTH = DEF_WIDTH_DATA,
  parameter int NUM_REG_BANK      = 1 << WIDTH_ADDR_LENGTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ReqAValid,
  input  logic [WIDTH_ADDR_LENGTH-1:0] ReqAAddr,
  input  logic [WIDTH_DATA_LENGTH-1:0] ReqAData,
  output logic                         ReqAReady,
  input  logic                         ReqBValid,
  input  logic [WIDTH_ADDR_LENGTH-1:0] ReqBAddr,
  input  logic [WIDTH_DATA_LENGTH-1:0] ReqBData,
  output logic                         ReqBReady,
  output logic                         RegWEn,
  output logic [WIDTH_ADDR_LENGTH-1:0] AddrD,
  output logic [WIDTH_DATA_LENGTH-1:0] DataD,
  input  logic                         IssueEn,
  input  logic [WIDTH_ADDR_LENGTH-1:0] IssueAddr,
  input  logic [WIDTH_ADDR_LENGTH-1:0] AddrA,
  input  logic [WIDTH_ADDR_LENGTH-1:0] AddrB,
  output logic                         BusyA,
  output logic                         BusyB,
  output logic                         Stall,
  output logic [WIDTH_ADDR_LENGTH:0]   Pending
);

  reqIdx_t                      ptr;
  logic                         contended;
  logic                         grantA;
  logic                         grantB;
  logic                         anyGrant;
  logic                         writeHit;
  logic [WIDTH_ADDR_LENGTH-1:0] grantAddr;
  logic [WIDTH_DATA_LENGTH-1:0] grantData;

  // Round-robin grant: a lone valid wins outright, the pointer side wins contention; nothing is granted in reset
  always_comb begin
    contended = ReqAValid & ReqBValid;
    grantA    = 1'b0;
    grantB    = 1'b0;
    if (!rst) begin
      if (contended) begin
        grantA = (ptr == REQ_A);
        grantB = (ptr == REQ_B);
      end else begin
        grantA = ReqAValid;
        grantB = ReqBValid;
      end
    end
  end

  // Steer the winning request onto the write path; register 0 is a sink that completes but never writes
  always_comb begin
    grantAddr = grantB ? ReqBAddr : ReqAAddr;
    grantData = grantB ? ReqBData : ReqAData;
    anyGrant  = grantA | grantB;
    writeHit  = anyGrant & (grantAddr != '0);
  end

  assign ReqAReady = grantA;
  assign ReqBReady = grantB;

  // Priority pointer flips only after a contended grant, handing priority to the side that lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= REQ_A;
    end else if (contended) begin
      ptr <= otherReq(ptr);
    end
  end

  // Write port: a one-cycle enable pulse per granted write, address/data held between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWEn <= 1'b0;
      AddrD  <= '0;
      DataD  <= '0;
    end else begin
      RegWEn <= writeHit;
      if (writeHit) begin
        AddrD <= grantAddr;
        DataD <= grantData;
      end
    end
  end

  // Issue marks the destination busy; a grant retires its address at the same edge as the write
  regbank_scoreboard #(
    .WIDTH_ADDR_LENGTH (WIDTH_ADDR_LENGTH),
    .NUM_REG_BANK      (NUM_REG_BANK)
  ) uScoreboard (
    .clk     (clk),
    .rst     (rst),
    .setEn   (IssueEn & ~rst),
    .setAddr (IssueAddr),
    .clrEn   (anyGrant),
    .clrAddr (grantAddr),
    .lookA   (AddrA),
    .lookB   (AddrB),
    .busyA   (BusyA),
    .busyB   (BusyB),
    .pending (Pending)
  );

  assign Stall = BusyA | BusyB;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Bench for regbank_wb_arbiter: directed scenarios with literal expectations plus randomized traffic.
// A behavioural model (busy array, pointer bit, last write) predicts every output at each falling edge.
// Requesters hold their requests until the model reports acceptance.
module tb_regbank_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ReqAValid, ReqBValid, ReqAReady, ReqBReady;
  logic [AW-1:0] ReqAAddr, ReqBAddr;
  logic [DW-1:0] ReqAData, ReqBData;
  logic          RegWEn;
  logic [AW-1:0] AddrD;
  logic [DW-1:0] DataD;
  logic          IssueEn;
  logic [AW-1:0] IssueAddr, AddrA, AddrB;
  logic          BusyA, BusyB, Stall;
  logic [AW:0]   Pending;

  int nChk  = 0;
  int nPass = 0;

  regbank_wb_arbiter #(
    .WIDTH_ADDR_LENGTH (AW),
    .WIDTH_DATA_LENGTH (DW),
    .NUM_REG_BANK      (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ReqAValid (ReqAValid),
    .ReqAAddr  (ReqAAddr),
    .ReqAData  (ReqAData),
    .ReqAReady (ReqAReady),
    .ReqBValid (ReqBValid),
    .ReqBAddr  (ReqBAddr),
    .ReqBData  (ReqBData),
    .ReqBReady (ReqBReady),
    .RegWEn    (RegWEn),
    .AddrD     (AddrD),
    .DataD     (DataD),
    .IssueEn   (IssueEn),
    .IssueAddr (IssueAddr),
    .AddrA     (AddrA),
    .AddrB     (AddrB),
    .BusyA     (BusyA),
    .BusyB     (BusyB),
    .Stall     (Stall),
    .Pending   (Pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
  endtask

  // Behavioural model state
  bit            mPtrB   = 1'b0;   // 1 when B has priority on contention
  bit            mBusy [NR];
  bit            mWen    = 1'b0;
  logic [AW-1:0] mAddrD  = '0;
  logic [DW-1:0] mDataD  = '0;
  bit            mGrantA = 1'b0;
  bit            mGrantB = 1'b0;

  // Model update at each edge, reset asynchronously like the design
  always @(posedge clk or posedge rst) begin : model
    bit            gA, gB;
    logic [AW-1:0] gAddr;
    logic [DW-1:0] gData;
    bit            nb [NR];
    if (rst) begin
      mPtrB   <= 1'b0;
      mWen    <= 1'b0;
      mAddrD  <= '0;
      mDataD  <= '0;
      mGrantA <= 1'b0;
      mGrantB <= 1'b0;
      for (int i = 0; i < NR; i++) mBusy[i] <= 1'b0;
    end else begin
      gA    = ReqAValid && (!ReqBValid || !mPtrB);
      gB    = ReqBValid && (!ReqAValid || mPtrB);
      gAddr = gA ? ReqAAddr : ReqBAddr;
      gData = gA ? ReqAData : ReqBData;
      if (ReqAValid && ReqBValid) mPtrB <= !mPtrB;
      mWen <= (gA || gB) && (gAddr != 0);
      if ((gA || gB) && (gAddr != 0)) begin
        mAddrD <= gAddr;
        mDataD <= gData;
      end
      nb = mBusy;
      if (gA || gB) nb[gAddr] = 1'b0;
      if (IssueEn && (IssueAddr != 0)) nb[IssueAddr] = 1'b1;
      nb[0] = 1'b0;
      mBusy   <= nb;
      mGrantA <= gA;
      mGrantB <= gB;
    end
  end

  // Every falling edge: all outputs against the model
  always @(negedge clk) begin : cmp
    logic [AW:0] cnt;
    logic        eA, eB;
    logic [48:0] act, exp;
    cnt = '0;
    for (int i = 0; i < NR; i++) if (mBusy[i]) cnt = cnt + 1'b1;
    eA  = !rst && ReqAValid && (!ReqBValid || !mPtrB);
    eB  = !rst && ReqBValid && (!ReqAValid || mPtrB);
    exp = {eA, eB, mWen, mAddrD, mDataD, mBusy[AddrA], mBusy[AddrB],
           mBusy[AddrA] | mBusy[AddrB], cnt};
    act = {ReqAReady, ReqBReady, RegWEn, AddrD, DataD, BusyA, BusyB, Stall, Pending};
    chk("cycle", 64'(act), 64'(exp));
  end

  task automatic toPos();
    @(posedge clk);
    #1;
  endtask

  task automatic toNeg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ReqAValid = 1'b0; ReqAAddr = '0; ReqAData = '0;
    ReqBValid = 1'b0; ReqBAddr = '0; ReqBData = '0;
    IssueEn = 1'b0; IssueAddr = '0; AddrA = '0; AddrB = '0;

    toPos(); toPos();
    toNeg();
    chk("rst_state", 64'({ReqAReady, ReqBReady, RegWEn, AddrD, DataD, Pending}), 64'd0);

    // Lone A request in the first cycle out of reset
    toPos(); rst = 1'b0;
    ReqAValid = 1'b1; ReqAAddr = 5'd5; ReqAData = 32'hDEADBEEF;
    toNeg(); chk("a_only_ready", 64'(ReqAReady), 64'd1);
    toPos(); ReqAValid = 1'b0;
    toNeg(); chk("a_only_write", 64'({RegWEn, AddrD, DataD}), 64'({1'b1, 5'd5, 32'hDEADBEEF}));
    toPos();
    toNeg(); chk("wen_one_cycle", 64'({RegWEn, AddrD}), 64'({1'b0, 5'd5}));

    // Contention straight after reset alternates A,B,A,B
    toPos(); rst = 1'b1;
    toPos(); rst = 1'b0;
    ReqAValid = 1'b1; ReqAAddr = 5'd1; ReqAData = 32'hA0;
    ReqBValid = 1'b1; ReqBAddr = 5'd2; ReqBData = 32'hB0;
    toNeg(); chk("rr1", 64'({ReqAReady, ReqBReady}), 64'b10);
    toPos(); ReqAData = 32'hA1;
    toNeg(); chk("rr2", 64'({ReqAReady, ReqBReady}), 64'b01);
    chk("rr2_wr", 64'({RegWEn, AddrD, DataD}), 64'({1'b1, 5'd1, 32'hA0}));
    toPos(); ReqBData = 32'hB1;
    toNeg(); chk("rr3", 64'({ReqAReady, ReqBReady}), 64'b10);
    chk("rr3_wr", 64'({RegWEn, AddrD, DataD}), 64'({1'b1, 5'd2, 32'hB0}));
    toPos(); ReqAData = 32'hA2;
    toNeg(); chk("rr4", 64'({ReqAReady, ReqBReady}), 64'b01);
    chk("rr4_wr", 64'({RegWEn, AddrD, DataD}), 64'({1'b1, 5'd1, 32'hA1}));
    toPos(); ReqBValid = 1'b0;
    toNeg(); chk("rr5_lone", 64'({ReqAReady, ReqBReady}), 64'b10);
    chk("rr5_wr", 64'({RegWEn, AddrD, DataD}), 64'({1'b1, 5'd2, 32'hB1}));
    toPos(); ReqAValid = 1'b0;
    toNeg(); chk("rr6_wr", 64'({RegWEn, AddrD, DataD}), 64'({1'b1, 5'd1, 32'hA2}));

    // Issue to 7 makes operand A busy; a B writeback to 7 retires it
    toPos(); IssueEn = 1'b1; IssueAddr = 5'd7;
    toPos(); IssueEn = 1'b0; AddrA = 5'd7;
    toNeg(); chk("busy7", 64'({BusyA, Stall, Pending}), 64'({1'b1, 1'b1, 6'd1}));
    toPos(); ReqBValid = 1'b1; ReqBAddr = 5'd7; ReqBData = 32'h77;
    toNeg(); chk("wb7_ready", 64'({ReqBReady, BusyA}), 64'b11);
    toPos(); ReqBValid = 1'b0;
    toNeg(); chk("wb7_clear", 64'({BusyA, Stall, Pending, RegWEn, AddrD}),
                 64'({1'b0, 1'b0, 6'd0, 1'b1, 5'd7}));

    // Issue to 9 in the same cycle as a grant to 9: the set wins
    toPos(); IssueEn = 1'b1; IssueAddr = 5'd9; AddrB = 5'd9;
    toPos(); ReqAValid = 1'b1; ReqAAddr = 5'd9; ReqAData = 32'h99;
    toNeg(); chk("busy9_pre", 64'({BusyB, Pending, ReqAReady}), 64'({1'b1, 6'd1, 1'b1}));
    toPos(); ReqAValid = 1'b0; IssueEn = 1'b0;
    toNeg(); chk("set_wins", 64'({BusyB, Pending, RegWEn, AddrD}), 64'({1'b1, 6'd1, 1'b1, 5'd9}));

    // Grant to register 0 completes without a write; issue to 0 is ignored
    toPos(); ReqAValid = 1'b1; ReqAAddr = 5'd0; ReqAData = 32'h1234;
    toNeg(); chk("a0_ready", 64'(ReqAReady), 64'd1);
    toPos(); ReqAValid = 1'b0; IssueEn = 1'b1; IssueAddr = 5'd0;
    toNeg(); chk("a0_nowrite", 64'({RegWEn, AddrD, DataD}), 64'({1'b0, 5'd9, 32'h99}));
    toPos(); IssueEn = 1'b0;
    toNeg(); chk("issue0", 64'(Pending), 64'd1);

    // Asynchronous reset with three busy registers and a write in flight
    toPos(); IssueEn = 1'b1; IssueAddr = 5'd3;
    toPos(); IssueAddr = 5'd4;
    toPos(); IssueEn = 1'b0;
    ReqAValid = 1'b1; ReqAAddr = 5'd12; ReqAData = 32'hC0FFEE;
    ReqBValid = 1'b1; ReqBAddr = 5'd13; ReqBData = 32'hBEEF;
    toNeg(); chk("three_busy", 64'(Pending), 64'd3);
    @(posedge clk); #3;
    chk("inflight", 64'({RegWEn, AddrD}), 64'({1'b1, 5'd12}));
    rst = 1'b1;
    #1;
    chk("async_rst", 64'({RegWEn, Pending, ReqAReady, ReqBReady, AddrD, DataD}), 64'd0);
    IssueEn = 1'b1; IssueAddr = 5'd5;
    toPos(); toPos();
    rst = 1'b0; ReqAValid = 1'b0; ReqBValid = 1'b0; IssueEn = 1'b0;
    toNeg(); chk("post_rst", 64'({Pending, RegWEn}), 64'd0);

    // Randomized traffic; requesters hold until the model reports acceptance
    for (int c = 0; c < 3000; c++) begin
      toPos();
      if (!ReqAValid || mGrantA) begin
        ReqAValid = ($urandom_range(0, 3) != 0);
        ReqAAddr  = AW'($urandom_range(0, 15));
        ReqAData  = $urandom;
      end
      if (!ReqBValid || mGrantB) begin
        ReqBValid = ($urandom_range(0, 3) != 0);
        ReqBAddr  = AW'($urandom_range(0, 15));
        ReqBData  = $urandom;
      end
      IssueEn   = ($urandom_range(0, 2) == 0);
      IssueAddr = AW'($urandom_range(0, 15));
      AddrA     = AW'($urandom_range(0, 15));
      AddrB     = AW'($urandom_range(0, 15));
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) begin
        #2;
        rst = 1'b1;
      end
    end
    toPos(); rst = 1'b0; ReqAValid = 1'b0; ReqBValid = 1'b0; IssueEn = 1'b0;
    toNeg();

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/regbank_wb_arbiter.md
REGBANK_WB_ARBITER -- requirements
Module: regbank_wb_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH_ADDR_LENGTH, default 5, register address width.
REQ-002 The block SHALL have parameter WIDTH_DATA_LENGTH, default 32, register data width.
REQ-003 The block SHALL have parameter NUM_REG_BANK, default 1 << WIDTH_ADDR_LENGTH, number of architectural registers.
REQ-004 The block SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-005 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 The block SHALL have ports ReqAValid, input, 1; ReqAAddr, input, WIDTH_ADDR_LENGTH; ReqAData, input, WIDTH_DATA_LENGTH: requester A (ALU writeback).
REQ-007 The block SHALL have port ReqAReady, output, 1, requester A accepted this cycle.
REQ-008 The block SHALL have ports ReqBValid, ReqBAddr, ReqBData and ReqBReady with the same widths: requester B (load writeback).
REQ-009 The block SHALL have ports RegWEn, output, 1; AddrD, output, WIDTH_ADDR_LENGTH; DataD, output, WIDTH_DATA_LENGTH: the register bank write port.
REQ-010 The block SHALL have ports IssueEn, input, 1; IssueAddr, input, WIDTH_ADDR_LENGTH: the destination of an issuing instruction.
REQ-011 The block SHALL have ports AddrA and AddrB, input, WIDTH_ADDR_LENGTH, the source operands under lookup.
REQ-012 The block SHALL have ports BusyA and BusyB, output, 1, and Stall, output, 1: scoreboard hazard flags.
REQ-013 The block SHALL have port Pending, output, WIDTH_ADDR_LENGTH+1, the count of busy registers.

Function
REQ-014 The block SHALL grant at most one requester per cycle; ReqXReady SHALL be combinational from the valid inputs and the priority pointer.
REQ-015 A handshake SHALL complete when ReqXValid and ReqXReady are both 1; each requester SHALL hold valid, address and data stable until accepted.
REQ-016 Arbitration SHALL be round-robin: a lone valid is granted immediately; on contention the pointer side wins and the pointer then moves to the other side.
REQ-017 The pointer SHALL change only on a contended grant.
REQ-018 The write port SHALL be registered with a latency of one cycle: the cycle after a grant, RegWEn=1 and AddrD/DataD equal the granted request for exactly one cycle; otherwise RegWEn=0 and AddrD/DataD hold their values.
REQ-019 A granted request to address 0 SHALL complete its handshake but leave RegWEn=0.
REQ-020 The scoreboard SHALL hold NUM_REG_BANK busy bits; IssueEn with a nonzero IssueAddr SHALL set busy[IssueAddr] at the clock edge.
REQ-021 A grant SHALL clear busy[granted address] at the same edge that registers the write.
REQ-022 If a set and a clear target the same address in one cycle, the set SHALL win.
REQ-023 busy[0] SHALL always read 0.
REQ-024 BusyA SHALL equal busy[AddrA] and BusyB SHALL equal busy[AddrB], combinationally from the registered bits.
REQ-025 Stall SHALL equal BusyA OR BusyB.
REQ-026 Pending SHALL be the registered population count of the busy bits, updated with them, range 0..NUM_REG_BANK-1.
REQ-027 A clear of a register that is not busy SHALL have no effect.

Reset
REQ-028 rst=1 SHALL immediately force RegWEn=0, AddrD=0, DataD=0, all busy bits to 0, Pending=0 and the pointer to A, including mid-operation.
REQ-029 While rst=1, ReqAReady and ReqBReady SHALL be 0 and IssueEn SHALL be ignored.
REQ-030 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-031 The width parameters and the requester index encoding (REQ_A=0, REQ_B=1) SHALL reside in a shared regbank_pkg.
REQ-032 The busy-bit array and its popcount SHALL be one sub-module, regbank_scoreboard; the arbitration and write-port register logic SHALL stay in the top module.

Verification
REQ-033 The bench SHALL cover: ReqAValid only, addr 5, data 0xDEADBEEF -> ReqAReady=1 that cycle; next cycle RegWEn=1, AddrD=5, DataD=0xDEADBEEF.
REQ-034 The bench SHALL cover: A and B valid for 4 cycles after reset (A addr 1, B addr 2) -> grants A,B,A,B; each loser holds its request until accepted.
REQ-035 The bench SHALL cover: IssueEn addr 7, then AddrA=7 -> BusyA=1, Stall=1, Pending=1; a B writeback to addr 7 -> next cycle BusyA=0, Pending=0.
REQ-036 The bench SHALL cover: an issue to addr 9 in the same cycle as a grant to addr 9 -> busy[9] stays 1.
REQ-037 The bench SHALL cover: a grant to addr 0 -> handshake completes with RegWEn=0 the next cycle; IssueEn addr 0 -> Pending unchanged.
REQ-038 The bench SHALL cover: rst asserted asynchronously with 3 registers busy and a grant in flight -> immediately RegWEn=0, Pending=0, both ready outputs 0.
